mcp3201_reader: RTL
===================

# mcp3201_reader

SPI master that reads a 12-bit MCP3201-style serial ADC. It is the reading counterpart of the mcp4921 DAC writer. On each trigger it drops CS, clocks 15 SCLK periods, captures the 12-bit result, checks the null bit, and presents the word with a one-cycle valid strobe. In the top level it sits beside the DAC driver and feeds a readout field of the SPI slave shift memory. Its first use is HV monitoring as an alternative to the sinc3 path.

## Interface
Parameters:
- CLKDIV, 4: SCLK half-period in CLK cycles; legal range 2..255.
- CSHIGH, 8: minimum CS-high gap in CLK cycles between conversions, counted from CS rising; legal range 1..255.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- i_resetn  input  1  synchronous, active-low reset.
- i_trig  input  1  conversion request. Level-sampled: any cycle in IDLE with i_trig=1 starts a conversion.
- i_MISO  input  1  ADC serial data out.
- o_SPICLK  output  1  ADC SCLK, idles low.
- o_CS  output  1  ADC chip select, active low, idles high.
- o_data  output  12  last good conversion result, held between conversions.
- o_valid  output  1  one-cycle strobe: o_data has been updated.
- o_nullerr  output  1  one-cycle strobe: conversion rejected because the null bit was 1.
- o_busy  output  1  high in every state except IDLE.
- o_missed  output  8  count of i_trig=1 cycles while o_busy; saturates at 255.

## Operation
- States: IDLE, LEAD, HIGH, LOW, GAP. A divider counter counts 0..CLKDIV-1 in LEAD/HIGH/LOW and 0..CSHIGH-1 in GAP. A bit counter counts 0..14.
- IDLE: o_CS=1, o_SPICLK=0. i_trig=1 → LEAD; clear the bit counter and the shift register.
- LEAD: o_CS=0, o_SPICLK=0 for CLKDIV cycles → HIGH.
- HIGH: o_SPICLK=1 for CLKDIV cycles → LOW.
  - On the CLK edge that enters HIGH, shift i_MISO into the 15-bit shift register, MSB first.
  - This edge is the SCLK rising edge; the ADC changes data on falling edges, so data is stable here.
- LOW: o_SPICLK=0 for CLKDIV cycles.
  - If bit counter < 14: increment it and go to HIGH.
  - Else go to GAP.
- Bit allocation of the 15 samples, in order:
  - s0, s1: sample/Hi-Z period, discarded.
  - s2: null bit, must be 0.
  - s3..s14: B11..B0.
- Entering GAP sets o_CS=1.
  - If s2=0: o_data ← {s3..s14} and o_valid pulses.
  - If s2=1: o_data is unchanged and o_nullerr pulses.
  - Both strobes occur on the same cycle CS rises. They never pulse together.
- GAP: o_CS=1 for CSHIGH cycles → IDLE. i_trig is ignored here and counted as missed.
- o_missed increments on every cycle with o_busy=1 and i_trig=1. There is no wrap: it holds at 255.
- Reset (i_resetn=0 at any edge, including mid-frame) forces:
  - state IDLE, o_CS=1, o_SPICLK=0;
  - o_data=0, o_valid=0, o_nullerr=0, o_missed=0;
  - both counters 0.
  - No partial result is ever published.
  - Reset overrides a simultaneous i_trig.

## Timing
Let cycle 0 be the edge where i_trig=1 is seen in IDLE; D=CLKDIV.
- Cycle 1: o_CS=0, o_busy=1.
- SCLK rising edge k (k=0..14) falls at cycle 1+D+2kD. MISO is sampled at that same edge.
- Last SCLK falling edge: cycle 1+30D.
- CS rises at cycle 1+31D, with o_valid or o_nullerr high for exactly that cycle.
- IDLE is re-entered at cycle 1+31D+CSHIGH; o_busy=0 from there.
- The earliest next trigger is accepted in that same cycle, so back-to-back period = 1+31D+CSHIGH cycles.
- D=4, CSHIGH=8: CS low at 1, first rise at 5, valid at 125, IDLE at 133, period 133.
- o_data changes only on the o_valid cycle. It is stable at all other times.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then idle 50 cycles → o_CS=1, o_SPICLK=0, o_data=0, o_busy=0, o_missed=0, no strobes.
- D=4, CSHIGH=8; ADC model returns 0xA5C with null=0; 1-cycle i_trig at cycle 0 → exactly 15 SCLK rising edges at cycles 5,13,…,117; o_valid only at 125; o_data=0xA5C; o_busy falls at 133.
- ADC model drives null bit=1 with data 0xFFF → o_nullerr at 125, no o_valid, o_data keeps the previous 0xA5C.
- i_trig held high continuously for 3 conversions with data 0x000, 0xFFF, 0x801 → results in that order; CS-high gap ≥8 cycles each; o_missed=255 (saturated) at end.
- i_resetn=0 for 1 cycle at cycle 60 mid-frame → o_CS=1 and o_SPICLK=0 next cycle, no o_valid ever, o_data=0; a new trigger then completes normally.
- D=2 boundary: data 0x001 → valid at cycle 63, o_data=0x001, SCLK high/low phases exactly 2 cycles each.

Source files
------------

// File: rtl/mcp3201_reader.sv
// mcp3201_reader: SPI master that reads one 12-bit MCP3201 conversion per trigger,
// rejects frames whose null bit is set, and publishes good words with a valid strobe.
module mcp3201_reader #(
  parameter int CLKDIV = 4,
  parameter int CSHIGH = 8
) (
  input  logic        CLK,
  input  logic        i_resetn,
  input  logic        i_trig,
  input  logic        i_MISO,
  output logic        o_SPICLK,
  output logic        o_CS,
  output logic [11:0] o_data,
  output logic        o_valid,
  output logic        o_nullerr,
  output logic        o_busy,
  output logic [7:0]  o_missed
);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, GAP} stateT;

  localparam logic [7:0] divLast = 8'(CLKDIV - 1);
  localparam logic [7:0] gapLast = 8'(CSHIGH - 1);
  localparam logic [3:0] bitLast = 4'd14;

  stateT       state, stateNext;
  logic [7:0]  divCnt, divCntNext;
  logic [3:0]  bitCnt, bitCntNext;
  // Only the newest 13 samples (null bit + B11..B0) matter; the two lead-in samples fall off the top.
  logic [12:0] shiftReg, shiftNext;
  logic        publish;

  // Next-state logic: every SCLK rising edge is the edge that enters HIGH, so MISO is shifted in there.
  always_comb begin
    stateNext  = state;
    divCntNext = divCnt + 8'd1;
    bitCntNext = bitCnt;
    shiftNext  = shiftReg;
    publish    = 1'b0;
    case (state)
      IDLE: begin
        divCntNext = 8'd0;
        if (i_trig) begin
          stateNext  = LEAD;
          bitCntNext = 4'd0;
          shiftNext  = 13'd0;
        end
      end
      LEAD: begin
        if (divCnt == divLast) begin
          stateNext  = HIGH;
          divCntNext = 8'd0;
          shiftNext  = {shiftReg[11:0], i_MISO};
        end
      end
      HIGH: begin
        if (divCnt == divLast) begin
          stateNext  = LOW;
          divCntNext = 8'd0;
        end
      end
      LOW: begin
        if (divCnt == divLast) begin
          divCntNext = 8'd0;
          if (bitCnt < bitLast) begin
            stateNext  = HIGH;
            bitCntNext = bitCnt + 4'd1;
            shiftNext  = {shiftReg[11:0], i_MISO};
          end else begin
            stateNext = GAP;
            publish   = 1'b1;
          end
        end
      end
      GAP: begin
        if (divCnt == gapLast) begin
          stateNext  = IDLE;
          divCntNext = 8'd0;
        end
      end
      default: begin
        stateNext  = IDLE;
        divCntNext = 8'd0;
      end
    endcase
  end

  // State and output registers; outputs follow the next state so they change on the same edge as the FSM.
  always_ff @(posedge CLK) begin
    if (!i_resetn) begin
      state     <= IDLE;
      divCnt    <= 8'd0;
      bitCnt    <= 4'd0;
      shiftReg  <= 13'd0;
      o_CS      <= 1'b1;
      o_SPICLK  <= 1'b0;
      o_data    <= 12'd0;
      o_valid   <= 1'b0;
      o_nullerr <= 1'b0;
      o_busy    <= 1'b0;
      o_missed  <= 8'd0;
    end else begin
      state     <= stateNext;
      divCnt    <= divCntNext;
      bitCnt    <= bitCntNext;
      shiftReg  <= shiftNext;
      o_CS      <= (stateNext == IDLE) || (stateNext == GAP);
      o_SPICLK  <= (stateNext == HIGH);
      o_busy    <= (stateNext != IDLE);
      o_valid   <= publish && !shiftReg[12];
      o_nullerr <= publish && shiftReg[12];
      if (publish && !shiftReg[12]) begin
        o_data <= shiftReg[11:0];
      end
      if (o_busy && i_trig && (o_missed != 8'hFF)) begin
        o_missed <= o_missed + 8'd1;
      end
    end
  end

endmodule
